// File: rtl/soc_opt_a_pulp_top_real_duplex_if.sv
// Valid/ready channel carrying one CGRA packet per transfer.
// The master drives val/msg and the slave answers with rdy.
interface soc_opt_a_pulp_top_real_duplex_if #(
    parameter int W = 185
);
    logic         val;
    logic         rdy;
    logic [W-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/soc_opt_a_pulp_top_real_duplex.sv
// Boot host plus CGRA stand-in. The host streams NUM_PKTS requests while it collects
// the echoed responses on the return channel, so both directions run at the same time.

module soc_opt_a_pulp_top_real_duplex_cgra #(
    parameter int CGRA_DATA_W = 35,
    parameter int CGRA_CTRL_W = 107,
    parameter int MCGR_PAY_W  = 158,
    parameter int CGRA_PKT_W  = 185
) (
    input  logic clk,
    input  logic rstn,
    soc_opt_a_pulp_top_real_duplex_if.slave  req,
    soc_opt_a_pulp_top_real_duplex_if.master rsp
);
    localparam int PLD_LSB = CGRA_CTRL_W + CGRA_DATA_W - 32;
    localparam int CMD_LSB = MCGR_PAY_W - 5;
    localparam int DST_LSB = CGRA_PKT_W - 8;
    localparam int SRC_LSB = CGRA_PKT_W - 4;

    logic                  live;
    logic [CGRA_PKT_W-1:0] req_mem [2];
    logic                  req_wp, req_rp;
    logic [1:0]            req_cnt;
    logic [CGRA_PKT_W-1:0] rsp_mem [2];
    logic                  rsp_wp, rsp_rp;
    logic [1:0]            rsp_cnt;
    logic                  lat;
    logic                  req_push, head_fwd, rsp_pop, head_can_move;
    logic [CGRA_PKT_W-1:0] head, rsp_word;

    // Ready only reflects occupancy; a pop in the same cycle never frees a slot early.
    assign req.rdy       = live && (req_cnt != 2'd2);
    assign req_push      = req.val && req.rdy;
    assign head          = req_mem[req_rp];
    assign head_can_move = (req_cnt != 2'd0) && (rsp_cnt != 2'd2);
    assign head_fwd      = head_can_move && lat;
    assign rsp.val       = (rsp_cnt != 2'd0);
    assign rsp.msg       = rsp_mem[rsp_rp];
    assign rsp_pop       = rsp.val && rsp.rdy;

    always_comb begin
        rsp_word                   = head;
        rsp_word[SRC_LSB +: 4]     = head[DST_LSB +: 4];
        rsp_word[DST_LSB +: 4]     = head[SRC_LSB +: 4];
        rsp_word[CMD_LSB +: 5]     = 5'd2;
        rsp_word[PLD_LSB +: 32]    = head[PLD_LSB +: 32] + 32'd1;
    end

    // lat marks that the head has already waited one cycle; it freezes while the response side is full.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live       <= 1'b0;
            req_mem[0] <= '0;
            req_mem[1] <= '0;
            req_wp     <= 1'b0;
            req_rp     <= 1'b0;
            req_cnt    <= 2'd0;
            lat        <= 1'b0;
        end else begin
            live <= 1'b1;
            if (req_push) begin
                req_mem[req_wp] <= req.msg;
                req_wp          <= ~req_wp;
            end
            if (head_fwd) begin
                req_rp <= ~req_rp;
            end
            req_cnt <= req_cnt + {1'b0, req_push} - {1'b0, head_fwd};
            if (head_fwd) begin
                lat <= 1'b0;
            end else if (head_can_move) begin
                lat <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_mem[0] <= '0;
            rsp_mem[1] <= '0;
            rsp_wp     <= 1'b0;
            rsp_rp     <= 1'b0;
            rsp_cnt    <= 2'd0;
        end else begin
            if (head_fwd) begin
                rsp_mem[rsp_wp] <= rsp_word;
                rsp_wp          <= ~rsp_wp;
            end
            if (rsp_pop) begin
                rsp_rp <= ~rsp_rp;
            end
            rsp_cnt <= rsp_cnt + {1'b0, head_fwd} - {1'b0, rsp_pop};
        end
    end
endmodule

module soc_opt_a_pulp_top_real_duplex #(
    parameter int CGRA_DATA_W = 35,
    parameter int CGRA_CTRL_W = 107,
    parameter int MCGR_PAY_W  = 158,
    parameter int PKT_HDR_W   = 27,
    parameter int CGRA_PKT_W  = 185,
    parameter int NUM_PKTS    = 4
) (
    input logic clk,
    input logic rstn
);
    localparam int PLD_LSB   = CGRA_CTRL_W + CGRA_DATA_W - 32;
    localparam int PRED_BIT  = CGRA_CTRL_W + 2;
    localparam int CADDR_LSB = MCGR_PAY_W - 16;
    localparam int DADDR_LSB = MCGR_PAY_W - 12;
    localparam int CMD_LSB   = MCGR_PAY_W - 5;
    localparam int DST_LSB   = CGRA_PKT_W - 8;
    localparam logic [3:0] PKT_MAX = 4'(NUM_PKTS);

    if ((CGRA_PKT_W != PKT_HDR_W + MCGR_PAY_W) ||
        (MCGR_PAY_W != 16 + CGRA_DATA_W + CGRA_CTRL_W)) begin : g_bad_widths
        $error("packet field widths do not add up");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
    state_t state, state_nx;

    logic                  tx_val, tx_rdy, rx_val, rx_rdy;
    logic [CGRA_PKT_W-1:0] tx_msg, rx_msg;
    logic [3:0]            sent_cnt, rcvd_cnt;
    logic [31:0]           checksum;
    logic                  done, err;
    logic                  tx_fire, rx_fire;
    logic                  unused_rx_bits;

    soc_opt_a_pulp_top_real_duplex_if #(.W(CGRA_PKT_W)) tx_ch ();
    soc_opt_a_pulp_top_real_duplex_if #(.W(CGRA_PKT_W)) rx_ch ();

    assign tx_ch.val      = tx_val;
    assign tx_ch.msg      = tx_msg;
    assign tx_rdy         = tx_ch.rdy;
    assign rx_val         = rx_ch.val;
    assign rx_msg         = rx_ch.msg;
    assign rx_ch.rdy      = rx_rdy;
    assign tx_fire        = tx_val && tx_rdy;
    assign rx_fire        = rx_val && rx_rdy;
    assign tx_val         = (state == SEND);
    assign rx_rdy         = (state == SEND) || (state == WAIT);
    assign done           = (state == DONE);
    assign unused_rx_bits = ^rx_msg;

    soc_opt_a_pulp_top_real_duplex_cgra #(
        .CGRA_DATA_W(CGRA_DATA_W),
        .CGRA_CTRL_W(CGRA_CTRL_W),
        .MCGR_PAY_W (MCGR_PAY_W),
        .CGRA_PKT_W (CGRA_PKT_W)
    ) u_cgra (
        .clk (clk),
        .rstn(rstn),
        .req (tx_ch),
        .rsp (rx_ch)
    );

    // Request i is derived purely from sent_cnt, so it stays stable while stalled.
    always_comb begin
        tx_msg                    = '0;
        tx_msg[DST_LSB +: 4]      = 4'd1;
        tx_msg[CMD_LSB +: 5]      = 5'd1;
        tx_msg[DADDR_LSB +: 7]    = {3'd0, sent_cnt};
        tx_msg[CADDR_LSB +: 4]    = sent_cnt;
        tx_msg[PLD_LSB +: 32]     = {28'd0, sent_cnt} + 32'd1;
        tx_msg[PRED_BIT]          = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = SEND;
            SEND:    if (tx_fire && (sent_cnt == PKT_MAX - 4'd1)) state_nx = WAIT;
            default: ;
        endcase
        if (rx_fire && (rcvd_cnt == PKT_MAX - 4'd1)) begin
            state_nx = DONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sent_cnt <= 4'd0;
            rcvd_cnt <= 4'd0;
            checksum <= 32'd0;
            err      <= 1'b0;
        end else begin
            if (tx_fire && (sent_cnt != PKT_MAX)) begin
                sent_cnt <= sent_cnt + 4'd1;
            end
            if (rx_fire && (rcvd_cnt != PKT_MAX)) begin
                rcvd_cnt <= rcvd_cnt + 4'd1;
                checksum <= checksum + rx_msg[PLD_LSB +: 32];
                if ((rx_msg[CMD_LSB +: 5] != 5'd2) || (rx_msg[DST_LSB +: 4] != 4'd0)) begin
                    err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_soc_opt_a_pulp_top_real_duplex.sv
// Directed bench for the duplex boot: plain boot, a stalled return channel, and a reset pulse in WAIT.
module tb_soc_opt_a_pulp_top_real_duplex;
    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    soc_opt_a_pulp_top_real_duplex dut (
        .clk (clk),
        .rstn(rstn)
    );

    soc_opt_a_pulp_top_real_duplex_if #(.W(185)) tx_mon ();
    soc_opt_a_pulp_top_real_duplex_if #(.W(185)) rx_mon ();

    assign tx_mon.val = dut.tx_val;
    assign tx_mon.rdy = dut.tx_rdy;
    assign tx_mon.msg = dut.tx_msg;
    assign rx_mon.val = dut.rx_val;
    assign rx_mon.rdy = dut.rx_rdy;
    assign rx_mon.msg = dut.rx_msg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [184:0] got, input logic [184:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [45:0] statusWord();
        return {tx_mon.val, rx_mon.val, rx_mon.rdy, tx_mon.rdy,
                dut.sent_cnt, dut.rcvd_cnt, dut.checksum, dut.done, dut.err};
    endfunction

    // Holds reset for n falling edges, checking the cleared state on each one.
    task automatic applyReset(input int n, input bit check_async);
        rstn = 1'b0;
        if (check_async) begin
            #1 checkOutput("reset_async", statusWord(), '0);
        end
        repeat (n) begin
            @(negedge clk);
            checkOutput("reset_state", statusWord(), '0);
            checkOutput("reset_no_x", $isunknown({statusWord(), tx_mon.msg, rx_mon.msg}), 0);
        end
        rstn = 1'b1;
        #1 checkOutput("release_idle", tx_mon.val, 0);
    endtask

    task automatic applyStimulus(input bit stall_rx, input bit pulse_wait);
        int           cyc        = 0;
        int           first_tx   = -1;
        int           first_rxv  = -1;
        int           stall_left = 0;
        bit           rx_seen    = 0;
        bit           pulsed     = 0;
        logic [184:0] tx0        = '0;
        logic [184:0] rx0        = '0;
        logic [184:0] tx0_exp;

        tx0_exp = {4'd0, 4'd1, 19'd0, 5'd1, 7'd0, 4'd0, 32'd1, 1'b1, 1'b0, 1'b0, 107'd0};
        while (!dut.done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checkOutput("boot_send", {tx_mon.val, tx_mon.rdy}, 2'b11);
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    checkOutput("stall_sent", dut.sent_cnt, 4);
                    checkOutput("stall_rcvd", dut.rcvd_cnt, 0);
                    checkOutput("stall_tx_rdy", tx_mon.rdy, 0);
                    checkOutput("stall_rx_val", rx_mon.val, 1);
                    release dut.rx_rdy;
                end
            end
            if (tx_mon.val && tx_mon.rdy && first_tx < 0) begin
                first_tx = cyc;
                tx0      = tx_mon.msg;
                if (stall_rx) begin
                    force dut.rx_rdy = 1'b0;
                    stall_left = 10;
                end
            end
            if (rx_mon.val && first_rxv < 0) begin
                first_rxv = cyc;
            end
            if (rx_mon.val && rx_mon.rdy && !rx_seen) begin
                rx_seen = 1'b1;
                rx0     = rx_mon.msg;
            end
            if (pulse_wait && !pulsed && dut.sent_cnt == 4'd4 && !dut.done) begin
                pulsed = 1'b1;
                applyReset(1, 1'b1);
            end
        end

        checkOutput("final_sent", dut.sent_cnt, 4);
        checkOutput("final_rcvd", dut.rcvd_cnt, 4);
        checkOutput("final_checksum", dut.checksum, 14);
        checkOutput("final_done", dut.done, 1);
        checkOutput("final_err", dut.err, 0);
        if (pulse_wait) begin
            checkOutput("pulse_hit", pulsed, 1);
        end
        if (!stall_rx && !pulse_wait) begin
            checkOutput("tx0_msg", tx0, tx0_exp);
            checkOutput("rx0_src", rx0[184:181], 1);
            checkOutput("rx0_dst", rx0[180:177], 0);
            checkOutput("rx0_cmd", rx0[157:153], 2);
            checkOutput("rx0_daddr", rx0[152:146], 0);
            checkOutput("rx0_payload", rx0[141:110], 2);
            checkOutput("rx0_pred", rx0[109], 1);
            checkOutput("rx_latency", first_rxv - first_tx, 3);
        end
    endtask

    initial begin
        rstn = 1'b0;
        $display("[TB] reset for 50 time units");
        applyReset(5, 1'b0);
        $display("[TB] free-running boot");
        applyStimulus(1'b0, 1'b0);
        applyReset(2, 1'b1);
        $display("[TB] boot with return channel held off");
        applyStimulus(1'b1, 1'b0);
        applyReset(2, 1'b1);
        $display("[TB] boot with reset pulse in WAIT");
        applyStimulus(1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/soc_opt_a_pulp_top_real_duplex.md
SOC_OPT_A_PULP_TOP_REAL_DUPLEX -- requirements
Module: soc_opt_a_pulp_top_real_duplex

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose these parameters (name, default, meaning):
- CGRA_DATA_W, 35: data word = payload 32, predicate 1, bypass 1, delay 1.
- CGRA_CTRL_W, 107: opaque CGRA control word.
- MCGR_PAY_W, 158: packet payload = cmd 5, data_addr 7, ctrl_addr 4, data 35, ctrl 107.
- PKT_HDR_W, 27: header = src 4, dst 4, src_x 3, src_y 3, dst_x 3, dst_y 3, opaque 6, vc 1.
- CGRA_PKT_W, 185: full packet = header (MSBs) followed by payload.
- NUM_PKTS, 4: packets issued per boot.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk, input, 1: system clock, rising-edge active.
- rstn, input, 1: asynchronous active-low reset.
REQ-004 SHALL have no other ports.
REQ-005 SHALL expose these internal nets for hierarchical probing:
- tx_val, tx_rdy, tx_msg[184:0]: host-to-CGRA channel.
- rx_val, rx_rdy, rx_msg[184:0]: CGRA-to-host channel.
- sent_cnt[3:0], rcvd_cnt[3:0], checksum[31:0], done, err.

Function
REQ-006 SHALL elaborate-time check that CGRA_PKT_W = PKT_HDR_W + MCGR_PAY_W and MCGR_PAY_W = 16 + CGRA_DATA_W + CGRA_CTRL_W, and SHALL fail elaboration on a mismatch.
REQ-007 Host engine SHALL run an FSM with states IDLE, SEND, WAIT, DONE. IDLE moves to SEND one cycle after reset release.
REQ-008 In SEND, host SHALL present packet i (i = sent_cnt) on tx with:
- src=0, dst=1, cmd=5'd1, data_addr=i, ctrl_addr=i, ctrl=0.
- data.payload=i+1; predicate=1, bypass=0, delay=0.
- all other header fields 0.
REQ-009 A transfer SHALL occur only on a cycle where val&&rdy at a rising clk edge. The producer SHALL hold msg stable while val is high and rdy is low.
REQ-010 sent_cnt SHALL increment on each tx transfer. After NUM_PKTS transfers the FSM SHALL go to WAIT and deassert tx_val.
REQ-011 CGRA stand-in SHALL accept tx through a 2-entry FIFO. tx_rdy SHALL be high iff that FIFO is not full, including on a full-and-pop cycle (no bypass).
REQ-012 For each accepted packet, the stand-in SHALL produce a response on rx exactly 2 cycles after the packet reaches the FIFO head, provided rx_rdy is high. The response SHALL have src and dst swapped, cmd=5'd2, data.payload = request payload + 1 (mod 2^32), and all other fields copied.
REQ-013 Response path SHALL use a 2-entry FIFO. If that FIFO is full, the stand-in SHALL stall its head and its latency timer SHALL not advance.
REQ-014 Host SHALL hold rx_rdy high in SEND and WAIT. On each rx transfer it SHALL:
- increment rcvd_cnt;
- add data.payload to checksum (mod 2^32);
- set err (sticky) if cmd != 2 or dst != 0.
REQ-015 When rcvd_cnt reaches NUM_PKTS, the FSM SHALL go to DONE and set done=1. DONE is terminal until reset.
REQ-016 Simultaneous tx and rx transfers in one cycle SHALL both be processed (full duplex).
REQ-017 Counters SHALL saturate at NUM_PKTS and SHALL never wrap.

Reset
REQ-018 While rstn=0, all of the following SHALL hold:
- FSM=IDLE, tx_val=0, rx_val=0, rx_rdy=0.
- sent_cnt=0, rcvd_cnt=0, checksum=0, done=0, err=0.
- both FIFOs empty, tx_rdy=0.
REQ-019 Asserting reset mid-operation SHALL immediately clear all state with no partial transfer completing. After release, the boot sequence SHALL restart from packet 0.
REQ-020 Reset assertion SHALL be asynchronous; deassertion SHALL take effect at the next rising clk.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Reset low 50 time units with clock period 10 -> all REQ-018 values hold throughout; no X on any probed net.
- Free-running boot, NUM_PKTS=4 -> sent_cnt=4, rcvd_cnt=4, checksum=14 (2+3+4+5), done=1, err=0.
- First rx transfer checked -> src=1, dst=0, cmd=2, payload=2, predicate=1.
- Force rx_rdy low for 10 cycles after the first tx -> tx_rdy falls after 4 accepted packets (both FIFOs full), no loss; final checksum=14.
- Reset pulse in WAIT state -> counters clear; rerun ends with checksum=14, done=1.
- Parameter mismatch (CGRA_DATA_W=34) -> elaboration error.
